// File: rtl/line_collector.sv
// line_collector: packs DEPTH consecutive bytes from the shifting chain into one word
// with a one-word output holding register. Optional XOR checksum under LINE_COLLECTOR_CHECKSUM_EN.
module line_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int CW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   flush,
  output logic [WIDTH*DEPTH-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
`ifdef LINE_COLLECTOR_CHECKSUM_EN
  output logic [WIDTH-1:0]       dout_chk,
`endif
  output logic [CW-1:0]          fill_cnt
);

  localparam int AW = WIDTH * DEPTH;

  logic [AW-1:0]    asm_r;
  logic [CW-1:0]    fill_r;
  logic [AW-1:0]    dout_r;
  logic             dout_valid_r;
  logic             full_s;
  logic             accept_s;
  logic             xfer_s;
  logic             consume_s;

  // FULL is decoded from the counter only, so din_ready never depends on dout_ready
  assign full_s    = (fill_r == CW'(DEPTH));
  assign accept_s  = din_valid && !full_s;
  assign xfer_s    = full_s && (!dout_valid_r || dout_ready);
  assign consume_s = dout_valid_r && dout_ready;

  assign din_ready  = !full_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign fill_cnt   = fill_r;

  // assembly register, fill counter and output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r        <= '0;
      fill_r       <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      if (xfer_s) begin
        dout_r       <= asm_r;
        dout_valid_r <= 1'b1;
        fill_r       <= '0;
      end else if (consume_s) begin
        dout_valid_r <= 1'b0;
      end else begin
        dout_valid_r <= dout_valid_r;
      end

      // flush only acts while filling; a completed word is never discarded
      if (!full_s) begin
        if (flush) begin
          asm_r  <= '0;
          fill_r <= '0;
        end else if (accept_s) begin
          asm_r  <= {asm_r[AW-WIDTH-1:0], din};
          fill_r <= fill_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          asm_r  <= asm_r;
        end
      end else begin
        asm_r <= asm_r;
      end
    end
  end

`ifdef LINE_COLLECTOR_CHECKSUM_EN
  logic [WIDTH-1:0] chk_acc_r;
  logic [WIDTH-1:0] dout_chk_r;

  assign dout_chk = dout_chk_r;

  // running XOR of accepted bytes, captured alongside dout on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc_r  <= '0;
      dout_chk_r <= '0;
    end else if (xfer_s) begin
      dout_chk_r <= chk_acc_r;
      chk_acc_r  <= '0;
    end else if (!full_s && flush) begin
      chk_acc_r  <= '0;
    end else if (accept_s) begin
      chk_acc_r  <= chk_acc_r ^ din;
    end else begin
      chk_acc_r  <= chk_acc_r;
    end
  end
`endif

endmodule

// File: tb/tb_line_collector.sv
// Directed and randomised self-checking bench for line_collector (WIDTH=8, DEPTH=5).
module tb_line_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = 5;
  localparam int AW    = WIDTH * DEPTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  logic [AW-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    fill_cnt;
`ifdef LINE_COLLECTOR_CHECKSUM_EN
  logic [WIDTH-1:0] dout_chk;
`endif

  int checks;
  int errors;

  line_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef LINE_COLLECTOR_CHECKSUM_EN
    .dout_chk   (dout_chk),
`endif
    .fill_cnt   (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer one byte and wait (bounded) until it has been accepted
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL send_timeout: din_ready=%0b required 1", din_ready);
    end
    step();
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", dout_valid); end
    checks++;
    if (dout !== 40'h0) begin errors++; $display("FAIL reset_dout: got %h required 0", dout); end
    checks++;
    if (fill_cnt !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d required 0", fill_cnt); end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", din_ready); end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = bytes[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (fill_cnt !== 5'd5 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_full: fill=%0d valid=%0b required 5/0", fill_cnt, dout_valid);
    end
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 40'h1122334455) begin
      errors++; $display("FAIL single_word: valid=%0b dout=%h required 1/1122334455", dout_valid, dout);
    end
    checks++;
    if (fill_cnt !== 5'd0) begin errors++; $display("FAIL single_fill: got %0d required 0", fill_cnt); end
    step();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: valid=%0b required 0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'hA0 + 8'(i));
    for (int i = 1; i <= 5; i++) send_byte(8'hB0 + 8'(i));
    step();
    step();
    checks++;
    if (din_ready !== 1'b0 || fill_cnt !== 5'd5) begin
      errors++; $display("FAIL b2b_stall: ready=%0b fill=%0d required 0/5", din_ready, fill_cnt);
    end
    checks++;
    if (dout_valid !== 1'b1 || dout !== 40'hA1A2A3A4A5) begin
      errors++; $display("FAIL b2b_hold: valid=%0b dout=%h required 1/a1a2a3a4a5", dout_valid, dout);
    end
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 40'hB1B2B3B4B5) begin
      errors++; $display("FAIL b2b_second: valid=%0b dout=%h required 1/b1b2b3b4b5", dout_valid, dout);
    end
    checks++;
    if (din_ready !== 1'b1 || fill_cnt !== 5'd0) begin
      errors++; $display("FAIL b2b_resume: ready=%0b fill=%0d required 1/0", din_ready, fill_cnt);
    end
    dout_ready = 1'b1;
    step();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%0b required 0", dout_valid); end
  endtask

  task automatic test_flush();
    dout_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    checks++;
    if (fill_cnt !== 5'd2) begin errors++; $display("FAIL flush_pre: fill=%0d required 2", fill_cnt); end
    din = 8'hCC;
    din_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    din_valid = 1'b0;
    checks++;
    if (fill_cnt !== 5'd0) begin errors++; $display("FAIL flush_clear: fill=%0d required 0", fill_cnt); end
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 40'h0102030405) begin
      errors++; $display("FAIL flush_word: valid=%0b dout=%h required 1/0102030405", dout_valid, dout);
    end
    step();
  endtask

  task automatic test_flush_full();
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'hC0 + 8'(i));
    for (int i = 1; i <= 5; i++) send_byte(8'hD0 + 8'(i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (fill_cnt !== 5'd5 || dout !== 40'hC1C2C3C4C5 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full: fill=%0d dout=%h valid=%0b required 5/c1c2c3c4c5/1", fill_cnt, dout, dout_valid);
    end
    dout_ready = 1'b1;
    step();
    checks++;
    if (dout !== 40'hD1D2D3D4D5 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full_kept: dout=%h valid=%0b required d1d2d3d4d5/1", dout, dout_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'hE0 + 8'(i));
    for (int i = 1; i <= 3; i++) send_byte(8'hF0 + 8'(i));
    step();
    checks++;
    if (fill_cnt !== 5'd3 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: fill=%0d valid=%0b required 3/1", fill_cnt, dout_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dout !== 40'h0 || dout_valid !== 1'b0 || fill_cnt !== 5'd0 || din_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_post: dout=%h valid=%0b fill=%0d ready=%0b required 0/0/0/1", dout, dout_valid, fill_cnt, din_ready);
    end
  endtask

`ifdef LINE_COLLECTOR_CHECKSUM_EN
  task automatic test_checksum();
    dout_ready = 1'b1;
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_byte(8'h3C);
    send_byte(8'hC3);
    send_byte(8'hFF);
    step();
    checks++;
    if (dout_valid !== 1'b1 || dout_chk !== 8'hFF) begin
      errors++; $display("FAIL checksum: valid=%0b chk=%h required 1/ff", dout_valid, dout_chk);
    end
    step();
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] sb [$];
    logic [AW-1:0] m_asm;
    logic [AW-1:0] m_dout;
    logic [AW-1:0] cur;
    logic [AW-1:0] exp_w;
    logic          m_dv;
    int            m_fill;
    int            cur_n;
    int            sent;
    int            consumed;
    int            cycles;
    logic          acc;
    logic          xfer;
    logic          cons;
    logic          dr;
    int            bad;
    m_asm = '0; m_dout = '0; cur = '0; m_dv = 1'b0;
    m_fill = 0; cur_n = 0; sent = 0; consumed = 0; cycles = 0; bad = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    while ((sent < 1000 || sb.size() != 0 || m_dv) && cycles < 20000) begin
      if (dout_valid !== m_dv || fill_cnt !== CW'(m_fill) || din_ready !== (m_fill != DEPTH) ||
          (m_dv && dout !== m_dout)) begin
        bad++;
        if (bad < 5) $display("FAIL rand_state: valid=%0b fill=%0d dout=%h required %0b/%0d/%h",
                              dout_valid, fill_cnt, dout, m_dv, m_fill, m_dout);
      end
      din_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      din = 8'($urandom_range(0, 255));
      dr = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = dr;
      acc  = din_valid && (m_fill != DEPTH);
      cons = m_dv && dr;
      xfer = (m_fill == DEPTH) && (!m_dv || dr);
      if (cons) begin
        checks++;
        exp_w = (sb.size() != 0) ? sb.pop_front() : '0;
        if (dout !== exp_w) begin
          errors++; $display("FAIL rand_word: dout=%h required %h", dout, exp_w);
        end
        consumed++;
      end
      if (xfer) begin
        m_dout = m_asm; m_dv = 1'b1; m_fill = 0;
      end else if (cons) begin
        m_dv = 1'b0;
      end
      if (acc) begin
        m_asm = {m_asm[AW-WIDTH-1:0], din};
        m_fill++;
        sent++;
        cur = {cur[AW-WIDTH-1:0], din};
        cur_n++;
        if (cur_n == DEPTH) begin sb.push_back(cur); cur_n = 0; end
      end
      step();
      cycles++;
    end
    din_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_state_total: %0d bad cycles required 0", bad); end
    checks++;
    if (consumed != 200 || sb.size() != 0) begin
      errors++; $display("FAIL rand_count: consumed=%0d pending=%0d required 200/0", consumed, sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    flush = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush();
    test_flush_full();
    test_reset_mid();
`ifdef LINE_COLLECTOR_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
